// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width; a single-chunk adder still needs a one-bit counter.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_adder_ripple.sv
// Combinational CHUNK-bit ripple-carry adder built from per-bit generate/propagate stages.
module chunk_ripple #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x_i,
    input  logic [CHUNK-1:0] y_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign g[i]     = x_i[i] & y_i[i];
        assign p[i]     = x_i[i] ^ y_i[i];
        assign sum_o[i] = p[i] ^ c[i];
        assign c[i+1]   = g[i] | (p[i] & c[i]);
    end

    assign cout_o     = c[CHUNK];
    assign c_msb_in_o = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one shared ripple chunk.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output state_t           dbg_state
);

    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int IW  = idx_w(NCH);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0)) begin : g_bad_params
        $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic                 carry_q, carry_d;
    logic                 c_out_q, c_out_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, done_q;
    logic [IW-1:0]        idx_q, idx_d;

    logic [CHUNK-1:0]     chunk_sum;
    logic                 chunk_cout;
    logic                 chunk_c_msb_in;
    logic [WIDTH+CHUNK-1:0] res_shift;
    logic                 last_chunk;

    // Operands shift right each RUN cycle, so the active chunk is always the low slice.
    chunk_ripple #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x_i        (a_q[CHUNK-1:0]),
        .y_i        (b_q[CHUNK-1:0]),
        .cin_i      (carry_q),
        .sum_o      (chunk_sum),
        .cout_o     (chunk_cout),
        .c_msb_in_o (chunk_c_msb_in)
    );

    // New chunk enters at the top; after NCH shifts chunk 0 sits at bit 0.
    assign res_shift  = {chunk_sum, res_q};
    assign last_chunk = (idx_q == IW'(NCH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | c_in;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = res_shift[WIDTH+CHUNK-1:CHUNK];
                carry_d = chunk_cout;
                idx_d   = idx_q + IW'(1);
                if (last_chunk) begin
                    state_d = DONE;
                    s_d     = res_d;
                    c_out_d = chunk_cout;
                    ovf_d   = chunk_cout ^ chunk_c_msb_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule
